noc_packetizer: RTL and testbench

NOC_PACKETIZER -- requirements
Module: noc_packetizer

---
 rtl/noc_packetizer.sv | 136 +++++++++++++
 tb/tb_noc_packetizer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_packetizer.sv
// Wraps a request (dest, vc, len) plus a payload stream into header + payload flits on one VC.
// Optional packet counter output pkt_cnt is enabled by defining NOC_PACKETIZER_STAT_EN.
module noc_packetizer #(
    parameter int unsigned FLIT_WIDTH = 32,
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned SRC_ID     = 0,
    localparam int unsigned VcW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_dest,
    input  logic [VcW-1:0]        req_vc,
    input  logic [7:0]            req_len,
    input  logic [FLIT_WIDTH-1:0] data,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic                  out_last,
    output logic [CHANNELS-1:0]   out_valid,
    input  logic [CHANNELS-1:0]   out_ready,
`ifdef NOC_PACKETIZER_STAT_EN
    output logic [15:0]           pkt_cnt,
`endif
    output logic                  busy
);

    localparam logic [31:0] SrcIdFull = 32'(SRC_ID);
    localparam logic [3:0]  SrcId     = SrcIdFull[3:0];

    typedef enum logic [1:0] {StIdle, StHeader, StPayload} state_e;

    state_e         state_q, state_d;
    logic [3:0]     dest_q, dest_d;
    logic [VcW-1:0] vc_q, vc_d;
    logic [7:0]     len_q, len_d;
    logic [7:0]     cnt_q, cnt_d;

    always_comb begin
        state_d    = state_q;
        dest_d     = dest_q;
        vc_d       = vc_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        req_ready  = 1'b0;
        data_ready = 1'b0;
        out_flit   = '0;
        out_last   = 1'b0;
        out_valid  = '0;
        unique case (state_q)
            StIdle: begin
                // Held low while in reset even though the state is already idle.
                req_ready = rst_n;
                if (req_valid) begin
                    dest_d  = req_dest;
                    vc_d    = req_vc;
                    len_d   = req_len;
                    state_d = StHeader;
                end
            end
            StHeader: begin
                out_valid[vc_q]                  = 1'b1;
                out_flit[FLIT_WIDTH-1 -: 4]      = dest_q;
                out_flit[FLIT_WIDTH-5 -: 4]      = SrcId;
                out_flit[FLIT_WIDTH-9 -: 8]      = len_q;
                out_last                         = (len_q == 8'd0);
                if (out_ready[vc_q]) begin
                    if (len_q == 8'd0) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StPayload;
                        cnt_d   = len_q;
                    end
                end
            end
            StPayload: begin
                out_flit        = data;
                out_valid[vc_q] = data_valid;
                data_ready      = out_ready[vc_q];
                out_last        = data_valid && (cnt_q == 8'd1);
                if (data_valid && out_ready[vc_q]) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy = (state_q != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            dest_q  <= '0;
            vc_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            vc_q    <= vc_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef NOC_PACKETIZER_STAT_EN
    logic [15:0] pkt_cnt_q, pkt_cnt_d;
    logic        last_accept;

    // out_last is only ever high alongside out_valid[vc_q].
    assign last_accept = out_last && out_ready[vc_q];

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (last_accept) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_noc_packetizer.sv
// Directed bench for noc_packetizer (FLIT_WIDTH=32, CHANNELS=2, SRC_ID=3).
// Status vector sts = {out_valid[1:0], out_last, data_ready, busy, req_ready}.
module tb_noc_packetizer;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_dest;
    logic        req_vc;
    logic [7:0]  req_len;
    logic [31:0] data;
    logic        data_valid;
    logic        data_ready;
    logic [31:0] out_flit;
    logic        out_last;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready;
    logic        busy;
`ifdef NOC_PACKETIZER_STAT_EN
    logic [15:0] pkt_cnt;
`endif

    logic [5:0]  sts;
    int          checks;
    int          errors;

    assign sts = {out_valid, out_last, data_ready, busy, req_ready};

    noc_packetizer #(
        .FLIT_WIDTH (32),
        .CHANNELS   (2),
        .SRC_ID     (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_dest   (req_dest),
        .req_vc     (req_vc),
        .req_len    (req_len),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .out_flit   (out_flit),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef NOC_PACKETIZER_STAT_EN
        .pkt_cnt    (pkt_cnt),
`endif
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents a request for one cycle; returns on the negedge after the handshake edge.
    task automatic do_req(input logic [3:0] d, input logic v, input logic [7:0] l);
        @(negedge clk);
        req_valid = 1'b1;
        req_dest  = d;
        req_vc    = v;
        req_len   = l;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if (sts !== 6'b00_0000) begin
            errors++;
            $display("FAIL reset_sts: got %b want %b", sts, 6'b00_0000);
        end
        checks++;
        if (out_flit !== 32'h0) begin
            errors++;
            $display("FAIL reset_flit: got %h want %h", out_flit, 32'h0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (sts !== 6'b00_0001) begin
            errors++;
            $display("FAIL reset_release_sts: got %b want %b", sts, 6'b00_0001);
        end
`ifdef NOC_PACKETIZER_STAT_EN
        checks++;
        if (pkt_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_pkt_cnt: got %h want %h", pkt_cnt, 16'h0);
        end
`endif
    endtask

    task automatic test_header_only;
        out_ready = 2'b11;
        do_req(4'd5, 1'b1, 8'd0);
        #1;
        checks++;
        if (sts !== 6'b10_1010) begin
            errors++;
            $display("FAIL hdr_only_sts: got %b want %b", sts, 6'b10_1010);
        end
        checks++;
        if (out_flit !== 32'h5300_0000) begin
            errors++;
            $display("FAIL hdr_only_flit: got %h want %h", out_flit, 32'h5300_0000);
        end
        @(negedge clk);
        #1;
        checks++;
        if (sts !== 6'b00_0001) begin
            errors++;
            $display("FAIL hdr_only_idle: got %b want %b", sts, 6'b00_0001);
        end
    endtask

    task automatic test_payload;
        logic [31:0] words [3];
        logic [5:0]  exp_sts;
        words[0] = 32'hAAAA_0001;
        words[1] = 32'hBBBB_0002;
        words[2] = 32'hCCCC_0003;
        out_ready = 2'b11;
        do_req(4'd2, 1'b0, 8'd3);
        #1;
        checks++;
        if (sts !== 6'b01_0010 || out_flit !== 32'h2303_0000) begin
            errors++;
            $display("FAIL pay_header: got sts %b flit %h want sts %b flit %h",
                     sts, out_flit, 6'b01_0010, 32'h2303_0000);
        end
        @(negedge clk);
        #1;
        checks++;
        if (sts !== 6'b00_0110) begin
            errors++;
            $display("FAIL pay_gap: got %b want %b", sts, 6'b00_0110);
        end
        for (int i = 0; i < 3; i++) begin
            data       = words[i];
            data_valid = 1'b1;
            exp_sts    = (i == 2) ? 6'b01_1110 : 6'b01_0110;
            #1;
            checks++;
            if (sts !== exp_sts || out_flit !== words[i]) begin
                errors++;
                $display("FAIL pay_flit%0d: got sts %b flit %h want sts %b flit %h",
                         i, sts, out_flit, exp_sts, words[i]);
            end
            @(negedge clk);
        end
        data_valid = 1'b0;
        #1;
        checks++;
        if (sts !== 6'b00_0001) begin
            errors++;
            $display("FAIL pay_idle: got %b want %b", sts, 6'b00_0001);
        end
    endtask

    task automatic test_backpressure;
        out_ready  = 2'b00;
        data       = 32'hD00D_F00D;
        data_valid = 1'b1;
        do_req(4'd9, 1'b1, 8'd1);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (sts !== 6'b10_0010 || out_flit !== 32'h9301_0000) begin
                errors++;
                $display("FAIL bp_hold%0d: got sts %b flit %h want sts %b flit %h",
                         i, sts, out_flit, 6'b10_0010, 32'h9301_0000);
            end
            @(negedge clk);
        end
        out_ready = 2'b10;
        #1;
        checks++;
        if (sts !== 6'b10_0010 || out_flit !== 32'h9301_0000) begin
            errors++;
            $display("FAIL bp_release: got sts %b flit %h want sts %b flit %h",
                     sts, out_flit, 6'b10_0010, 32'h9301_0000);
        end
        @(negedge clk);
        #1;
        checks++;
        if (sts !== 6'b10_1110 || out_flit !== 32'hD00D_F00D) begin
            errors++;
            $display("FAIL bp_payload: got sts %b flit %h want sts %b flit %h",
                     sts, out_flit, 6'b10_1110, 32'hD00D_F00D);
        end
        @(negedge clk);
        data_valid = 1'b0;
        #1;
        checks++;
        if (sts !== 6'b00_0001) begin
            errors++;
            $display("FAIL bp_idle: got %b want %b", sts, 6'b00_0001);
        end
    endtask

    task automatic test_vc_isolation;
        out_ready = 2'b10;
        do_req(4'd1, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (sts !== 6'b01_1010 || out_flit !== 32'h1300_0000) begin
                errors++;
                $display("FAIL vc_iso%0d: got sts %b flit %h want sts %b flit %h",
                         i, sts, out_flit, 6'b01_1010, 32'h1300_0000);
            end
            @(negedge clk);
        end
        out_ready = 2'b01;
        @(negedge clk);
        #1;
        checks++;
        if (sts !== 6'b00_0001) begin
            errors++;
            $display("FAIL vc_iso_idle: got %b want %b", sts, 6'b00_0001);
        end
    endtask

    task automatic test_req_wait;
        out_ready = 2'b00;
        do_req(4'd6, 1'b0, 8'd0);
        req_valid = 1'b1;
        req_dest  = 4'd8;
        req_vc    = 1'b1;
        req_len   = 8'd0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (sts !== 6'b01_1010 || out_flit !== 32'h6300_0000) begin
                errors++;
                $display("FAIL wait_busy%0d: got sts %b flit %h want sts %b flit %h",
                         i, sts, out_flit, 6'b01_1010, 32'h6300_0000);
            end
            @(negedge clk);
        end
        out_ready = 2'b01;
        @(negedge clk);
        #1;
        checks++;
        if (sts !== 6'b00_0001) begin
            errors++;
            $display("FAIL wait_idle: got %b want %b", sts, 6'b00_0001);
        end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++;
        if (sts !== 6'b10_1010 || out_flit !== 32'h8300_0000) begin
            errors++;
            $display("FAIL wait_second_hdr: got sts %b flit %h want sts %b flit %h",
                     sts, out_flit, 6'b10_1010, 32'h8300_0000);
        end
        out_ready = 2'b10;
        @(negedge clk);
        #1;
        checks++;
        if (sts !== 6'b00_0001) begin
            errors++;
            $display("FAIL wait_done: got %b want %b", sts, 6'b00_0001);
        end
    endtask

    task automatic test_reset_mid;
        out_ready = 2'b11;
        do_req(4'd7, 1'b1, 8'd4);
        #1;
        checks++;
        if (sts !== 6'b10_0010 || out_flit !== 32'h7304_0000) begin
            errors++;
            $display("FAIL rmid_hdr: got sts %b flit %h want sts %b flit %h",
                     sts, out_flit, 6'b10_0010, 32'h7304_0000);
        end
        @(negedge clk);
        data       = 32'hE000_0001;
        data_valid = 1'b1;
        #1;
        checks++;
        if (sts !== 6'b10_0110) begin
            errors++;
            $display("FAIL rmid_flit1: got %b want %b", sts, 6'b10_0110);
        end
        @(negedge clk);
        data  = 32'hF000_0002;
        rst_n = 1'b0;
        #1;
        checks++;
        if (sts !== 6'b00_0000 || out_flit !== 32'h0) begin
            errors++;
            $display("FAIL rmid_in_reset: got sts %b flit %h want sts %b flit %h",
                     sts, out_flit, 6'b00_0000, 32'h0);
        end
        @(negedge clk);
        rst_n      = 1'b1;
        data_valid = 1'b0;
        #1;
        checks++;
        if (sts !== 6'b00_0001) begin
            errors++;
            $display("FAIL rmid_release: got %b want %b", sts, 6'b00_0001);
        end
        do_req(4'd4, 1'b0, 8'd0);
        #1;
        checks++;
        if (sts !== 6'b01_1010 || out_flit !== 32'h4300_0000) begin
            errors++;
            $display("FAIL rmid_fresh_hdr: got sts %b flit %h want sts %b flit %h",
                     sts, out_flit, 6'b01_1010, 32'h4300_0000);
        end
        @(negedge clk);
        #1;
        checks++;
        if (sts !== 6'b00_0001) begin
            errors++;
            $display("FAIL rmid_idle: got %b want %b", sts, 6'b00_0001);
        end
    endtask

`ifdef NOC_PACKETIZER_STAT_EN
    task automatic test_stat;
        // One packet has completed since the mid-packet reset.
        checks++;
        if (pkt_cnt !== 16'h0001) begin
            errors++;
            $display("FAIL stat_count: got %h want %h", pkt_cnt, 16'h0001);
        end
        @(negedge clk);
        force dut.pkt_cnt_q = 16'hFFFE;
        @(posedge clk);
        release dut.pkt_cnt_q;
        @(negedge clk);
        #1;
        checks++;
        if (pkt_cnt !== 16'hFFFE) begin
            errors++;
            $display("FAIL stat_preload: got %h want %h", pkt_cnt, 16'hFFFE);
        end
        out_ready = 2'b11;
        do_req(4'd3, 1'b0, 8'd0);
        @(negedge clk);
        #1;
        checks++;
        if (pkt_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL stat_ffff: got %h want %h", pkt_cnt, 16'hFFFF);
        end
        do_req(4'd3, 1'b1, 8'd0);
        @(negedge clk);
        #1;
        checks++;
        if (pkt_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL stat_wrap: got %h want %h", pkt_cnt, 16'h0000);
        end
    endtask
`endif

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_dest   = 4'd0;
        req_vc     = 1'b0;
        req_len    = 8'd0;
        data       = 32'h0;
        data_valid = 1'b0;
        out_ready  = 2'b00;
        test_reset();
        test_header_only();
        test_payload();
        test_backpressure();
        test_vc_isolation();
        test_req_wait();
        test_reset_mid();
`ifdef NOC_PACKETIZER_STAT_EN
        test_stat();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
